// File: rtl/raycast_slice_scheduler_pkg.sv
// Shared constants and FSM state type for the raycast slice scheduler.
package raycast_pkg;

    localparam int FRAC_SCALE     = 1000;
    localparam int DEG_WRAP       = 360;

    localparam int DEF_NUM_SLICES = 160;
    localparam int DEF_STEP_MILLI = 375;
    localparam int DEF_HALF_FOV   = 30;
    localparam int DEF_MAX_DIST   = 1023;

    typedef enum logic [1:0] {IDLE, REQ, OUT, DONE} state_t;

endpackage

// File: rtl/raycast_slice_scheduler_if.sv
// Request channel to the arithmetic pipeline and column channel to the renderer.
interface raycast_slice_scheduler_if;

    logic               ray_req;
    logic [7:0]         ray_slice;
    logic [8:0]         ray_angle_int;
    logic [9:0]         ray_angle_frac;
    logic               ray_ack;
    logic signed [20:0] ray_dist;

    logic               col_valid;
    logic               col_ready;
    logic [7:0]         col_slice;
    logic signed [20:0] col_dist;

    modport master (
        output ray_req, ray_slice, ray_angle_int, ray_angle_frac,
        input  ray_ack, ray_dist,
        output col_valid, col_slice, col_dist,
        input  col_ready
    );

    modport slave (
        input  ray_req, ray_slice, ray_angle_int, ray_angle_frac,
        output ray_ack, ray_dist,
        input  col_valid, col_slice, col_dist,
        output col_ready
    );

endinterface

// File: rtl/raycast_slice_scheduler_angle_step.sv
// Combinational angle adder in split int/thousandths form: carry or borrow on the
// thousandths, then wrap the integer degrees into 0..359.
module raycast_angle_step
    import raycast_pkg::*;
#(
    parameter bit SUB    = 1'b0,
    parameter int D_INT  = 0,
    parameter int D_FRAC = DEF_STEP_MILLI
) (
    input  logic [8:0] in_int,
    input  logic [9:0] in_frac,
    output logic [8:0] out_int,
    output logic [9:0] out_frac
);

    int frac_t;
    int int_t;

    always_comb begin
        frac_t = int'(in_frac);
        int_t  = int'(in_int);
        if (SUB) begin
            frac_t = frac_t - D_FRAC;
            int_t  = int_t - D_INT;
            if (frac_t < 0) begin
                frac_t = frac_t + FRAC_SCALE;
                int_t  = int_t - 1;
            end
            if (int_t < 0) int_t = int_t + DEG_WRAP;
        end else begin
            frac_t = frac_t + D_FRAC;
            int_t  = int_t + D_INT;
            if (frac_t >= FRAC_SCALE) begin
                frac_t = frac_t - FRAC_SCALE;
                int_t  = int_t + 1;
            end
            if (int_t >= DEG_WRAP) int_t = int_t - DEG_WRAP;
        end
        out_int  = 9'(int_t);
        out_frac = 10'(frac_t);
    end

endmodule

// File: rtl/raycast_slice_scheduler.sv
// Frame sequencer: one distance request and one column per slice, angle stepped per slice.
// Define RAYCAST_SCHED_CLAMP_EN to clamp captured distances into 0..MAX_DIST.
module raycast_slice_scheduler
    import raycast_pkg::*;
#(
    parameter int NUM_SLICES = DEF_NUM_SLICES,
    parameter int STEP_MILLI = DEF_STEP_MILLI,
    parameter int HALF_FOV   = DEF_HALF_FOV,
    parameter int MAX_DIST   = DEF_MAX_DIST
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        frame_start,
    input  logic [8:0]                  player_angle_int,
    input  logic [9:0]                  player_angle_frac,
    output logic                        busy,
    output logic                        frame_done,
    raycast_slice_scheduler_if.master   bus
);

    localparam logic [7:0] LAST_SLICE = 8'(NUM_SLICES - 1);

    state_t             state;
    state_t             state_nx;
    logic [7:0]         slice_q;
    logic [8:0]         ang_int_q;
    logic [9:0]         ang_frac_q;
    logic signed [20:0] dist_q;
    logic signed [20:0] dist_in;
    logic [8:0]         start_int;
    logic [9:0]         start_frac;
    logic [8:0]         next_int;
    logic [9:0]         next_frac;
    logic               last_slice;

    assign last_slice = (slice_q == LAST_SLICE);

    raycast_angle_step #(.SUB(1'b1), .D_INT(HALF_FOV), .D_FRAC(0)) u_start (
        .in_int   (player_angle_int),
        .in_frac  (player_angle_frac),
        .out_int  (start_int),
        .out_frac (start_frac)
    );

    raycast_angle_step #(.SUB(1'b0), .D_INT(0), .D_FRAC(STEP_MILLI)) u_step (
        .in_int   (ang_int_q),
        .in_frac  (ang_frac_q),
        .out_int  (next_int),
        .out_frac (next_frac)
    );

`ifdef RAYCAST_SCHED_CLAMP_EN
    localparam logic signed [20:0] MAX_DIST_S = 21'(MAX_DIST);

    always_comb begin
        if (bus.ray_dist < 0)               dist_in = '0;
        else if (bus.ray_dist > MAX_DIST_S) dist_in = MAX_DIST_S;
        else                                dist_in = bus.ray_dist;
    end
`else
    assign dist_in = bus.ray_dist;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // NOTE: every output gets a default before the case, so no path leaves one unassigned (no latch).
    always_comb begin
        state_nx      = state;
        busy          = 1'b0;
        frame_done    = 1'b0;
        bus.ray_req   = 1'b0;
        bus.col_valid = 1'b0;
        case (state)
            IDLE: if (frame_start) state_nx = REQ;
            REQ: begin
                busy        = 1'b1;
                bus.ray_req = 1'b1;
                if (bus.ray_ack) state_nx = OUT;
            end
            OUT: begin
                busy          = 1'b1;
                bus.col_valid = 1'b1;
                if (bus.col_ready) state_nx = last_slice ? DONE : REQ;
            end
            DONE: begin
                busy       = 1'b1;
                frame_done = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Player angle is only looked at on an accepted frame_start.
    always_ff @(posedge clk) begin
        if (reset) begin
            slice_q    <= '0;
            ang_int_q  <= '0;
            ang_frac_q <= '0;
            dist_q     <= '0;
        end else begin
            case (state)
                IDLE: if (frame_start) begin
                    slice_q    <= '0;
                    ang_int_q  <= start_int;
                    ang_frac_q <= start_frac;
                end
                REQ: if (bus.ray_ack) dist_q <= dist_in;
                OUT: if (bus.col_ready && !last_slice) begin
                    slice_q    <= slice_q + 8'd1;
                    ang_int_q  <= next_int;
                    ang_frac_q <= next_frac;
                end
                default: ;
            endcase
        end
    end

    assign bus.ray_slice      = slice_q;
    assign bus.ray_angle_int  = ang_int_q;
    assign bus.ray_angle_frac = ang_frac_q;
    assign bus.col_slice      = slice_q;
    assign bus.col_dist       = dist_q;

endmodule

// File: tb/tb_raycast_slice_scheduler.sv
// Directed bench for raycast_slice_scheduler: angle table, clamp table, and
// hand-written sequences for frame timing, backpressure and mid-frame reset.
module tb_raycast_slice_scheduler;
    import raycast_pkg::*;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               frame_start = 1'b0;
    logic [8:0]         p_int = '0;
    logic [9:0]         p_frac = '0;
    logic               busy;
    logic               frame_done;
    logic               ack_drv = 1'b1;
    logic               ready_drv = 1'b1;
    logic signed [20:0] dist_drv = '0;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int p_int;
        int p_frac;
        int slice;
        int e_int;
        int e_frac;
    } ang_vec_t;

    typedef struct {
        int din;
        int dexp;
    } dist_vec_t;

    ang_vec_t  avec[9];
    dist_vec_t dvec[3];

    always #5 clk = ~clk;

    raycast_slice_scheduler_if bus ();

    assign bus.ray_ack   = ack_drv;
    assign bus.ray_dist  = dist_drv;
    assign bus.col_ready = ready_drv;

    raycast_slice_scheduler dut (
        .clk               (clk),
        .reset             (reset),
        .frame_start       (frame_start),
        .player_angle_int  (p_int),
        .player_angle_frac (p_frac),
        .busy              (busy),
        .frame_done        (frame_done),
        .bus               (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench at the negedge of cycle 1 (frame_start was high in cycle 0).
    task automatic start_frame(input int pi, input int pf);
        @(negedge clk);
        p_int       = 9'(pi);
        p_frac      = 10'(pf);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int first_busy, last_busy, done_cycle, done_count, overlap;

        avec[0] = '{90,  0,   0,   60,  0};
        avec[1] = '{90,  0,   1,   60,  375};
        avec[2] = '{90,  0,   8,   63,  0};
        avec[3] = '{10,  500, 0,   340, 500};
        avec[4] = '{359, 0,   80,  359, 0};
        avec[5] = '{359, 0,   82,  359, 750};
        avec[6] = '{359, 0,   83,  0,   125};
        avec[7] = '{0,   0,   159, 29,  625};
        avec[8] = '{359, 999, 1,   330, 374};

`ifdef RAYCAST_SCHED_CLAMP_EN
        dvec[0] = '{1048575, 1023};
        dvec[1] = '{-5,      0};
        dvec[2] = '{500,     500};
`else
        dvec[0] = '{1048575, 1048575};
        dvec[1] = '{-5,      -5};
        dvec[2] = '{500,     500};
`endif

        // Reset state
        step(2);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_ray_req", bus.ray_req, 0);
        check("rst_col_valid", bus.col_valid, 0);
        check("rst_ray_slice", bus.ray_slice, 0);
        check("rst_ray_angle_int", bus.ray_angle_int, 0);
        check("rst_ray_angle_frac", bus.ray_angle_frac, 0);
        check("rst_col_dist", bus.col_dist, 0);
        reset = 1'b0;

        // Angle table: slice n requests in cycle 2n+1 with handshakes tied high
        for (int i = 0; i < 9; i++) begin
            start_frame(avec[i].p_int, avec[i].p_frac);
            step(2 * avec[i].slice);
            check($sformatf("ang%0d_req", i), bus.ray_req, 1);
            check($sformatf("ang%0d_slice", i), bus.ray_slice, avec[i].slice);
            check($sformatf("ang%0d_int", i), bus.ray_angle_int, avec[i].e_int);
            check($sformatf("ang%0d_frac", i), bus.ray_angle_frac, avec[i].e_frac);
            do_reset();
        end

        // Distance table (clamped or passed through)
        for (int i = 0; i < 3; i++) begin
            dist_drv = 21'(dvec[i].din);
            start_frame(90, 0);
            step(1);
            check($sformatf("dist%0d_valid", i), bus.col_valid, 1);
            check($sformatf("dist%0d_col_dist", i), bus.col_dist, dvec[i].dexp);
            do_reset();
        end

        // Whole frame timing: busy, frame_done, and request/column exclusivity
        dist_drv   = 21'sd100;
        first_busy = -1;
        last_busy  = -1;
        done_cycle = -1;
        done_count = 0;
        overlap    = 0;
        start_frame(90, 0);
        for (int c = 1; c <= 400; c++) begin
            if (busy) begin
                if (first_busy < 0) first_busy = c;
                last_busy = c;
            end
            if (frame_done) begin
                if (done_cycle < 0) done_cycle = c;
                done_count++;
            end
            if (bus.ray_req && bus.col_valid) overlap++;
            step(1);
        end
        check("frame_done_cycle", done_cycle, 321);
        check("frame_done_pulses", done_count, 1);
        check("busy_first", first_busy, 1);
        check("busy_last", last_busy, 321);
        check("req_col_overlap", overlap, 0);

        // Backpressure on slice 5 column, then on slice 6 request
        dist_drv = 21'sd777;
        start_frame(90, 0);
        step(11);
        ready_drv = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_col_valid%0d", k), bus.col_valid, 1);
            check($sformatf("bp_col_slice%0d", k), bus.col_slice, 5);
            check($sformatf("bp_col_dist%0d", k), bus.col_dist, 777);
            check($sformatf("bp_no_req%0d", k), bus.ray_req, 0);
            step(1);
        end
        ready_drv = 1'b1;
        ack_drv   = 1'b0;
        step(1);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("ack_req%0d", k), bus.ray_req, 1);
            check($sformatf("ack_slice%0d", k), bus.ray_slice, 6);
            check($sformatf("ack_int%0d", k), bus.ray_angle_int, 62);
            check($sformatf("ack_frac%0d", k), bus.ray_angle_frac, 250);
            check($sformatf("ack_no_col%0d", k), bus.col_valid, 0);
            step(1);
        end
        ack_drv  = 1'b1;
        dist_drv = 21'sd321;
        step(1);
        check("ack_col_valid", bus.col_valid, 1);
        check("ack_col_slice", bus.col_slice, 6);
        check("ack_col_dist", bus.col_dist, 321);
        do_reset();

        // Reset mid-frame at slice 40, restart, ignored frame_start
        start_frame(90, 0);
        step(80);
        check("mid_slice40", bus.ray_slice, 40);
        check("mid_angle40", bus.ray_angle_int, 75);
        reset = 1'b1;
        step(1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_req", bus.ray_req, 0);
        check("mid_rst_col_valid", bus.col_valid, 0);
        check("mid_rst_frame_done", frame_done, 0);
        check("mid_rst_slice", bus.ray_slice, 0);
        check("mid_rst_angle_int", bus.ray_angle_int, 0);
        check("mid_rst_col_dist", bus.col_dist, 0);
        reset = 1'b0;
        start_frame(90, 0);
        check("restart_req", bus.ray_req, 1);
        check("restart_slice", bus.ray_slice, 0);
        check("restart_int", bus.ray_angle_int, 60);
        check("restart_frac", bus.ray_angle_frac, 0);
        step(4);
        frame_start = 1'b1;
        p_int       = 9'd200;
        step(1);
        frame_start = 1'b0;
        step(1);
        check("ignore_start_slice", bus.ray_slice, 3);
        check("ignore_start_int", bus.ray_angle_int, 61);
        check("ignore_start_frac", bus.ray_angle_frac, 125);
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
